// File: rtl/abr_serial_addsub.sv
// abr_serial_addsub: multi-limb serial adder/subtractor.
// Computes A+B or A-B over NUM_LIMBS limbs of RADIX bits. Limbs stream LSB-first,
// one per handshake. The carry/borrow is held in a register between limbs, and
// each result limb is registered behind a valid/ready output stage.
//
// Optional feature macro: ABR_SERIAL_ADDSUB_ZERO_FLAG_EN adds zero_o, which is
// high on the last limb when every result limb of the operation was zero.
//
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   zeroize_i       synchronous clear of all state (same effect as reset)
//   in_valid_i/in_ready_o, sub_i, a_i, b_i       input limb handshake and operands
//   out_valid_o/out_ready_i, s_o, out_last_o     result limb handshake and data
//   cout_o          final carry (add) or borrow (sub), valid with out_last_o
//   zero_o          (optional) all-limbs-zero flag, valid with out_last_o
module abr_serial_addsub #(
    parameter int unsigned RADIX     = 32,
    parameter int unsigned NUM_LIMBS = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             zeroize_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             sub_i,
    input  logic [RADIX-1:0] a_i,
    input  logic [RADIX-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [RADIX-1:0] s_o,
    output logic             out_last_o,
`ifdef ABR_SERIAL_ADDSUB_ZERO_FLAG_EN
    output logic             zero_o,
`endif
    output logic             cout_o
);

    localparam int unsigned CNT_W = $clog2(NUM_LIMBS + 1);
    localparam int unsigned SUM_W = RADIX + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic               valid_q, valid_d;
    logic [RADIX-1:0]   s_q, s_d;
    logic               last_q, last_d;
    logic               cout_q, cout_d;
    logic               zacc_q, zacc_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               first;
    logic               mode_eff;
    logic               cin;
    logic [RADIX-1:0]   b_eff;
    logic [SUM_W-1:0]   sum_full;
    logic               c_next;
    logic [RADIX-1:0]   sum;
    logic               is_last;
    logic               zacc_next;

    // Single output stage with pass-through ready.
    assign in_ready_o = !valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;

    // First limb uses sub_i directly for both the mode and the carry-in.
    assign first    = (state_q == IDLE);
    assign mode_eff = first ? sub_i : mode_q;
    assign cin      = first ? sub_i : carry_q;
    assign b_eff    = mode_eff ? ~b_i : b_i;
    assign sum_full = SUM_W'(a_i) + SUM_W'(b_eff) + SUM_W'(cin);
    assign c_next   = sum_full[RADIX];
    assign sum      = sum_full[RADIX-1:0];

    // Accepted limb is limb cnt_q+1 (1-based); it is last when that equals NUM_LIMBS.
    assign is_last   = first ? (NUM_LIMBS == 1) : (cnt_q == CNT_W'(NUM_LIMBS - 1));
    assign zacc_next = (first | zacc_q) & (sum == '0);

    // Next-state, datapath and output-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        s_d     = s_q;
        last_d  = last_q;
        cout_d  = cout_q;
        zacc_d  = zacc_q;
        zero_d  = zero_q;

        if (accept) begin
            s_d     = sum;
            last_d  = is_last;
            valid_d = 1'b1;
            // A subtract reports borrow, which is the inverted carry.
            cout_d  = is_last & (mode_eff ^ c_next);
            zacc_d  = zacc_next;
            zero_d  = is_last & zacc_next;
            if (first) begin
                mode_d = sub_i;
            end
            if (is_last) begin
                state_d = IDLE;
                cnt_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = BUSY;
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = c_next;
            end
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end

        if (zeroize_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            carry_d = 1'b0;
            mode_d  = 1'b0;
            valid_d = 1'b0;
            s_d     = '0;
            last_d  = 1'b0;
            cout_d  = 1'b0;
            zacc_d  = 1'b0;
            zero_d  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            s_q     <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            zacc_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            s_q     <= s_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            zacc_q  <= zacc_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid_o = valid_q;
    assign s_o         = s_q;
    assign out_last_o  = last_q;
    assign cout_o      = cout_q;
`ifdef ABR_SERIAL_ADDSUB_ZERO_FLAG_EN
    assign zero_o      = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zacc_q ^ zero_q;
`endif

endmodule

// File: doc/abr_serial_addsub.md
Name: abr_serial_addsub

Overview:
Multi-limb serial adder/subtractor that computes A+B or A-B over NUM_LIMBS limbs of RADIX bits each. Limbs stream LSB-first, one limb per handshake, and the carry/borrow is held in a register between limbs. It is the sequential, wide-operand successor to the single-cycle RADIX-bit full adder and serves the ML-DSA/ML-KEM big-number datapaths, for example in key-material arithmetic. Output limbs are registered and support valid/ready backpressure.

Parameters:
RADIX, 32, limb width in bits (>=2)
NUM_LIMBS, 8, limbs per operand (>=1); operand width = RADIX*NUM_LIMBS
CNT_W, $clog2(NUM_LIMBS+1), limb counter width (derived, not overridden)

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
zeroize_i  input  1  synchronous clear of all state, same effect as reset
in_valid_i  input  1  input limb valid
in_ready_o  output  1  block can accept a limb
sub_i  input  1  0=add, 1=subtract; sampled only on the first limb of an operation
a_i  input  RADIX  limb of A
b_i  input  RADIX  limb of B
out_valid_o  output  1  result limb valid
out_ready_i  input  1  downstream accepts the result limb
s_o  output  RADIX  result limb
out_last_o  output  1  marks the final (most-significant) limb
cout_o  output  1  final carry (add) or borrow (sub); valid only when out_valid_o & out_last_o

Behaviour:
- Reset (rst_b=0, async) or zeroize_i=1 (sync, highest priority) clears state as follows: state=IDLE, limb_cnt=0, carry=0, mode=0, out_valid_o=0, s_o=0, out_last_o=0, cout_o=0. Any operation in flight is discarded, with no partial output.
- Input handshake: a limb is accepted when in_valid_i & in_ready_o. in_ready_o = !out_valid_o | out_ready_i, which gives a single registered output stage with pass-through ready.
- Per-limb arithmetic: {c_next, sum} = a_i + (mode ? ~b_i : b_i) + cin. The sum is computed at RADIX+1 bits, and sum is RADIX bits.
- cin on the first limb = sub_i. On later limbs, cin = the carry register.
- The mode register captures sub_i on the first limb. The mode applied to the first limb is sub_i directly.
- Mid-operation changes on sub_i are ignored.
- FSM has two states:
  - IDLE: waiting for the first limb. On accept, latch the mode, set limb_cnt=1, and store carry=c_next. If NUM_LIMBS==1, stay in IDLE and mark the output last. Otherwise go to BUSY.
  - BUSY: on each accept, limb_cnt++ and carry=c_next. When the accepted limb is limb NUM_LIMBS, mark the output last, clear limb_cnt and carry, and return to IDLE.
- Output register: on accept, s_o<=sum, out_last_o<=(limb is last), and out_valid_o<=1. On the last limb, cout_o<=(mode ? ~c_next : c_next). On non-last limbs, cout_o<=0.
- out_valid_o clears when out_ready_i is high with no new accept.
- Latency: 1 cycle from input accept to out_valid_o. Full throughput is 1 limb/cycle when out_ready_i is held high.
- Backpressure: while out_valid_o & !out_ready_i, in_ready_o=0. s_o, out_last_o and cout_o are held stable, and the carry does not advance.
- Back-to-back operations: the first limb of the next operation may be accepted in the cycle immediately after the last limb of the previous one, with no bubble. The carry is not carried across operations.
- Subtraction wrap-around: when A<B, the result is the two's-complement of A-B modulo 2^(RADIX*NUM_LIMBS), with cout_o=1 (borrow).
- Addition overflow: the result is modulo 2^(RADIX*NUM_LIMBS), with cout_o=1.
- in_valid_i deasserting mid-operation is a legal stall. State is held indefinitely.

Optional Feature:
ABR_SERIAL_ADDSUB_ZERO_FLAG_EN
- Defined: adds output port zero_o (1 bit) and a sticky "all result limbs zero" register. The register is set to 1 at the start of each operation and ANDed with (sum==0) on every accepted limb. zero_o is valid alongside cout_o on the last limb and is 0 otherwise; it resets to 0.
- Not defined: port and logic are absent. Functional behaviour of every other port is identical.

Test Plan:
- Add, RADIX=32, NUM_LIMBS=8, A=2^256-1, B=1, sub=0, out_ready=1 -> 8 limbs of 0x00000000, out_last on the 8th, cout_o=1 (zero_o=1 if enabled).
- Sub, A=0, B=1 -> 8 limbs of 0xFFFFFFFF, cout_o=1 (borrow). Then sub with A=5, B=3 -> limb0=0x2, others 0, cout_o=0.
- Backpressure: toggle out_ready_i at random for a 100-operation random add/sub sweep -> each s_o stays stable while stalled, in_ready_o=0 while stalled, and every result matches a 256-bit reference model.
- Back-to-back: two operations with in_valid held high for 16 cycles and opposite modes -> 16 consecutive out_valid cycles, out_last at limbs 8 and 16, and the second operation is unaffected by the first operation's final carry.
- sub_i toggled mid-operation on limbs 2-7 -> result equals that of the mode sampled on limb 0.
- Reset and zeroize mid-operation: assert rst_b=0 asynchronously after 3 limbs, then repeat using zeroize_i -> all outputs 0 immediately (reset) or next cycle (zeroize), and the next operation starts from limb 0 with carry 0 and a correct result.
